ceyloniac_fetch: RTL and testbench
==================================

CEYLONIAC_FETCH -- requirements
Module: ceyloniac_fetch

Interface
REQ-001 Parameter RAM_ADDR_WIDTH, default 16: width of the PC and memory address.
REQ-002 Parameter RAM_DATA_WIDTH, default 32: width of the instruction word.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 fetch_reset  in  1  reset, asynchronous, active-high.
REQ-005 fetch_enable  in  1  level; permits new fetches.
REQ-006 pc_in  in  RAM_ADDR_WIDTH  current PC from the PC register (its pc_out).
REQ-007 pc_write  out  1  one-cycle pulse; loads pc_next into the PC register.
REQ-008 pc_next  out  RAM_ADDR_WIDTH  value to load into the PC register.
REQ-009 mem_addr  out  RAM_ADDR_WIDTH  instruction-memory read address.
REQ-010 mem_read_req  out  1  level read request, held until mem_ready or abort.
REQ-011 mem_ready  in  1  mem_data valid this cycle.
REQ-012 mem_data  in  RAM_DATA_WIDTH  instruction read data.
REQ-013 branch_valid  in  1  one-cycle redirect request.
REQ-014 branch_target  in  RAM_ADDR_WIDTH  redirect address.
REQ-015 ir_valid  out  1  ir_data holds a fetched instruction.
REQ-016 ir_data  out  RAM_DATA_WIDTH  instruction register.
REQ-017 ir_ready  in  1  decoder accepts ir_data when ir_valid=1.
REQ-018 fetch_stall_count  out  16  count of memory wait cycles (see Configuration).

Function
REQ-019 The FSM SHALL have states IDLE, REQ, HOLD; all outputs registered except mem_addr=pc_in, mem_read_req=(state==REQ), pc_write and pc_next.
REQ-020 IDLE: fetch_enable=1 -> REQ next cycle; otherwise stay.
REQ-021 REQ: mem_ready=1 -> ir_data<=mem_data, ir_valid<=1, pc_write=1 with pc_next=pc_in+1 in the same cycle, -> HOLD.
REQ-022 REQ with mem_ready=0: fetch_enable=0 -> IDLE (request dropped); else stay in REQ.
REQ-023 HOLD: ir_ready=1 -> ir_valid<=0, -> REQ if fetch_enable=1 else IDLE; ir_ready=0 -> hold ir_data and ir_valid unchanged.
REQ-024 pc_next=pc_in+1 SHALL wrap modulo 2^RAM_ADDR_WIDTH (all-ones -> 0).
REQ-025 Minimum throughput: one instruction per 2 cycles (REQ with mem_ready=1, HOLD with ir_ready=1).
REQ-026 branch_valid=1 in any state SHALL take priority: pc_write=1, pc_next=branch_target, ir_valid<=0, a same-cycle mem_ready response discarded, -> REQ if fetch_enable=1 else IDLE.
REQ-027 The PC register SHALL update on the edge ending the pc_write cycle, so the following REQ cycle presents the new PC on mem_addr.
REQ-028 pc_write SHALL never be asserted in two consecutive cycles except for back-to-back branch_valid.
REQ-029 ir_data SHALL change only on an accepted mem_ready in REQ.

Reset
REQ-030 fetch_reset=1 SHALL asynchronously force state=IDLE, ir_valid=0, ir_data=0, fetch_stall_count=0; pc_write=0 and mem_read_req=0 while reset is asserted.
REQ-031 Reset mid-REQ SHALL abort the request; a mem_ready during reset SHALL be ignored.
REQ-032 The first fetch after reset release SHALL begin in the cycle after fetch_enable is sampled high in IDLE.

Configuration
REQ-033 Macro CEYLONIAC_FETCH_STALL_COUNT_EN defined: fetch_stall_count increments each cycle in REQ with mem_ready=0 and branch_valid=0, saturating at 16'hFFFF.
REQ-034 Macro undefined: fetch_stall_count SHALL be constant 0 with no counter logic; all other behaviour is identical.

Verification
REQ-035 Reset, pc_in=0x0000, fetch_enable=1, mem_ready=1 always, ir_ready=1 -> ir_data sequence of mem words for 0,1,2; pc_write every 2nd cycle, pc_next=1,2,3.
REQ-036 mem_ready low 3 cycles in REQ -> mem_read_req held 4 cycles, mem_addr stable; fetch_stall_count=3 with the macro, 0 without.
REQ-037 ir_ready=0 for 5 cycles in HOLD -> ir_valid=1 and ir_data stable, no pc_write, no mem_read_req.
REQ-038 branch_valid=1, branch_target=0x0100 in the same cycle as mem_ready=1 -> pc_next=0x0100, ir_valid stays 0, next mem_addr=0x0100.
REQ-039 pc_in=0xFFFF, mem_ready=1 -> pc_next=0x0000.
REQ-040 fetch_reset asserted mid-REQ -> immediate IDLE, ir_valid=0, mem_read_req=0; resume on fetch_enable after release.

Source files
------------

// File: rtl/ceyloniac_fetch.sv
// Instruction fetch unit: IDLE/REQ/HOLD sequencer driving the PC register,
// instruction memory and instruction register. Define CEYLONIAC_FETCH_STALL_COUNT_EN for the stall counter.
module ceyloniac_fetch #(
  parameter int RAM_ADDR_WIDTH = 16,
  parameter int RAM_DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      fetch_reset,
  input  logic                      fetch_enable,
  input  logic [RAM_ADDR_WIDTH-1:0] pc_in,
  output logic                      pc_write,
  output logic [RAM_ADDR_WIDTH-1:0] pc_next,
  output logic [RAM_ADDR_WIDTH-1:0] mem_addr,
  output logic                      mem_read_req,
  input  logic                      mem_ready,
  input  logic [RAM_DATA_WIDTH-1:0] mem_data,
  input  logic                      branch_valid,
  input  logic [RAM_ADDR_WIDTH-1:0] branch_target,
  output logic                      ir_valid,
  output logic [RAM_DATA_WIDTH-1:0] ir_data,
  input  logic                      ir_ready,
  output logic [15:0]               fetch_stall_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [RAM_ADDR_WIDTH-1:0] ADDR_ONE = RAM_ADDR_WIDTH'(1);

  state_t                    state;
  logic [RAM_ADDR_WIDTH-1:0] pc_inc;
  logic                      fetch_accept;

  // Natural wrap of the adder gives all-ones -> 0.
  assign pc_inc       = pc_in + ADDR_ONE;
  assign mem_addr     = pc_in;
  assign mem_read_req = (state == REQ);

  // A redirect outranks a same-cycle memory response, which is dropped.
  assign fetch_accept = (state == REQ) && mem_ready && !branch_valid;

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    pc_write = 1'b0;
    pc_next  = pc_inc;
    if (!fetch_reset) begin
      if (branch_valid) begin
        pc_write = 1'b1;
        pc_next  = branch_target;
      end else if (fetch_accept) begin
        pc_write = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge fetch_reset) begin
    if (fetch_reset) begin
      state    <= IDLE;
      ir_valid <= 1'b0;
      ir_data  <= '0;
    end else if (branch_valid) begin
      ir_valid <= 1'b0;
      state    <= fetch_enable ? REQ : IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (fetch_enable) state <= REQ;
        end
        REQ: begin
          if (mem_ready) begin
            ir_data  <= mem_data;
            ir_valid <= 1'b1;
            state    <= HOLD;
          end else if (!fetch_enable) begin
            state <= IDLE;
          end
        end
        HOLD: begin
          if (ir_ready) begin
            ir_valid <= 1'b0;
            state    <= fetch_enable ? REQ : IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          ir_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef CEYLONIAC_FETCH_STALL_COUNT_EN
  // Counts cycles the memory keeps an outstanding request waiting; saturates.
  always_ff @(posedge clk or posedge fetch_reset) begin
    if (fetch_reset) begin
      fetch_stall_count <= 16'h0000;
    end else if ((state == REQ) && !mem_ready && !branch_valid &&
                 (fetch_stall_count != 16'hFFFF)) begin
      fetch_stall_count <= fetch_stall_count + 16'd1;
    end
  end
`else
  assign fetch_stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_ceyloniac_fetch.sv
// Directed bench for ceyloniac_fetch: models the PC register and a memory
// whose word at address A is {16'hC0DE, A}.
module tb_ceyloniac_fetch;

  logic        clk = 1'b0;
  logic        fetch_reset;
  logic        fetch_enable;
  logic [15:0] pc_in;
  logic        pc_write;
  logic [15:0] pc_next;
  logic [15:0] mem_addr;
  logic        mem_read_req;
  logic        mem_ready;
  logic [31:0] mem_data;
  logic        branch_valid;
  logic [15:0] branch_target;
  logic        ir_valid;
  logic [31:0] ir_data;
  logic        ir_ready;
  logic [15:0] fetch_stall_count;

  logic        pc_load;
  logic [15:0] pc_load_val;

  int checks = 0;
  int errors = 0;

`ifdef CEYLONIAC_FETCH_STALL_COUNT_EN
  localparam logic [15:0] STALL_EXP = 16'd3;
`else
  localparam logic [15:0] STALL_EXP = 16'd0;
`endif

  always #5 clk = ~clk;

  ceyloniac_fetch #(.RAM_ADDR_WIDTH(16), .RAM_DATA_WIDTH(32)) dut (
    .clk               (clk),
    .fetch_reset       (fetch_reset),
    .fetch_enable      (fetch_enable),
    .pc_in             (pc_in),
    .pc_write          (pc_write),
    .pc_next           (pc_next),
    .mem_addr          (mem_addr),
    .mem_read_req      (mem_read_req),
    .mem_ready         (mem_ready),
    .mem_data          (mem_data),
    .branch_valid      (branch_valid),
    .branch_target     (branch_target),
    .ir_valid          (ir_valid),
    .ir_data           (ir_data),
    .ir_ready          (ir_ready),
    .fetch_stall_count (fetch_stall_count)
  );

  // PC register and instruction memory of the surrounding core.
  always @(posedge clk) begin
    if (pc_write)     pc_in <= pc_next;
    else if (pc_load) pc_in <= pc_load_val;
  end
  assign mem_data = {16'hC0DE, mem_addr};

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Inputs are driven just after an edge; outputs settle 1 time unit later.
  task automatic settle();
    #1;
  endtask

  initial begin
    pc_in         = 16'h0000;
    pc_load       = 1'b0;
    pc_load_val   = 16'h0000;
    fetch_reset   = 1'b1;
    fetch_enable  = 1'b0;
    mem_ready     = 1'b1;
    branch_valid  = 1'b0;
    branch_target = 16'h0000;
    ir_ready      = 1'b1;
    tick(); tick();

    // Reset state, with a mem_ready present that must be ignored.
    check("rst_ir_valid", 32'(ir_valid), 32'd0);
    check("rst_ir_data", ir_data, 32'h0);
    check("rst_mem_req", 32'(mem_read_req), 32'd0);
    check("rst_pc_write", 32'(pc_write), 32'd0);
    check("rst_stall", 32'(fetch_stall_count), 32'd0);

    // Streaming fetch from 0: fetch, accept, fetch, accept...
    fetch_reset  = 1'b0;
    fetch_enable = 1'b1;
    settle();
    check("idle_no_req", 32'(mem_read_req), 32'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("seq%0d_req", i), 32'(mem_read_req), 32'd1);
      check($sformatf("seq%0d_addr", i), 32'(mem_addr), 32'(i));
      check($sformatf("seq%0d_pcw", i), 32'(pc_write), 32'd1);
      check($sformatf("seq%0d_pcn", i), 32'(pc_next), 32'(i + 1));
      tick();
      check($sformatf("seq%0d_irv", i), 32'(ir_valid), 32'd1);
      check($sformatf("seq%0d_ird", i), ir_data, 32'hC0DE0000 + 32'(i));
      check($sformatf("seq%0d_hold_pcw", i), 32'(pc_write), 32'd0);
      if (i == 2) mem_ready = 1'b0;
      tick();
    end

    // Memory stalls three cycles at address 3.
    for (int i = 0; i < 3; i++) begin
      check($sformatf("stall%0d_req", i), 32'(mem_read_req), 32'd1);
      check($sformatf("stall%0d_addr", i), 32'(mem_addr), 32'h0003);
      check($sformatf("stall%0d_pcw", i), 32'(pc_write), 32'd0);
      tick();
    end
    mem_ready = 1'b1;
    ir_ready  = 1'b0;
    settle();
    check("stall_end_req", 32'(mem_read_req), 32'd1);
    check("stall_end_pcn", 32'(pc_next), 32'h0004);
    check("stall_count", 32'(fetch_stall_count), 32'(STALL_EXP));
    tick();

    // Decoder back-pressure for five cycles.
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp%0d_irv", i), 32'(ir_valid), 32'd1);
      check($sformatf("bp%0d_ird", i), ir_data, 32'hC0DE0003);
      check($sformatf("bp%0d_pcw", i), 32'(pc_write), 32'd0);
      check($sformatf("bp%0d_req", i), 32'(mem_read_req), 32'd0);
      tick();
    end
    ir_ready = 1'b1;
    tick();

    // Branch in REQ together with mem_ready: response discarded.
    branch_valid  = 1'b1;
    branch_target = 16'h0100;
    settle();
    check("br_req_pcw", 32'(pc_write), 32'd1);
    check("br_req_pcn", 32'(pc_next), 32'h0100);
    tick();
    branch_valid = 1'b0;
    mem_ready    = 1'b0;
    settle();
    check("br_req_irv", 32'(ir_valid), 32'd0);
    check("br_req_ird", ir_data, 32'hC0DE0003);
    check("br_req_addr", 32'(mem_addr), 32'h0100);
    check("br_req_mreq", 32'(mem_read_req), 32'd1);
    mem_ready = 1'b1;
    tick();

    // Branch while holding an unaccepted instruction.
    check("br_hold_ird", ir_data, 32'hC0DE0100);
    ir_ready      = 1'b0;
    branch_valid  = 1'b1;
    branch_target = 16'h0200;
    settle();
    check("br_hold_pcn", 32'(pc_next), 32'h0200);
    tick();
    branch_valid = 1'b0;
    ir_ready     = 1'b1;
    mem_ready    = 1'b0;
    pc_load      = 1'b1;
    pc_load_val  = 16'hFFFF;
    settle();
    check("br_hold_irv", 32'(ir_valid), 32'd0);
    check("br_hold_addr", 32'(mem_addr), 32'h0200);
    tick();

    // PC wrap at all-ones.
    pc_load   = 1'b0;
    mem_ready = 1'b1;
    settle();
    check("wrap_addr", 32'(mem_addr), 32'hFFFF);
    check("wrap_pcn", 32'(pc_next), 32'h0000);
    tick();
    check("wrap_ird", ir_data, 32'hC0DEFFFF);
    tick();

    // Asynchronous reset in the middle of a request.
    check("pre_rst_req", 32'(mem_read_req), 32'd1);
    fetch_reset = 1'b1;
    settle();
    check("mid_rst_req", 32'(mem_read_req), 32'd0);
    check("mid_rst_pcw", 32'(pc_write), 32'd0);
    check("mid_rst_irv", 32'(ir_valid), 32'd0);
    check("mid_rst_ird", ir_data, 32'h0);
    tick();
    check("rst_hold_irv", 32'(ir_valid), 32'd0);
    fetch_reset = 1'b0;
    settle();
    check("rel_idle_req", 32'(mem_read_req), 32'd0);
    tick();
    check("rel_req", 32'(mem_read_req), 32'd1);
    check("rel_addr", 32'(mem_addr), 32'h0000);
    check("rel_pcn", 32'(pc_next), 32'h0001);
    tick();
    check("rel_ird", ir_data, 32'hC0DE0000);
    tick();

    // Dropping fetch_enable while waiting on memory abandons the request.
    mem_ready    = 1'b0;
    fetch_enable = 1'b0;
    settle();
    check("drop_req_before", 32'(mem_read_req), 32'd1);
    tick();
    check("drop_req_after", 32'(mem_read_req), 32'd0);
    check("drop_pcw", 32'(pc_write), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
